// File: rtl/rpn_seq.sv
// rpn_seq: key-driven RPN stack sequencer that works on an external
// register file. A debounced one-key press selects an op (bank chosen by
// mode). The op is carried out by a short FSM, and the top two stack
// entries are mirrored on top/next once it finishes.
module rpn_seq #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [3:0]  key,
  input  logic [15:0] val,
  output logic [2:0]  rf_raddr0,
  output logic [2:0]  rf_raddr1,
  input  logic [15:0] rf_rdata0,
  input  logic [15:0] rf_rdata1,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [15:0] top,
  output logic [15:0] next,
  output logic [7:0]  counter,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_EXEC    = 3'd2,
    S_WB      = 3'd3,
    S_WB2     = 3'd4,
    S_REFRESH = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_PUSH = 4'd0,  OP_POP = 4'd1,  OP_DUP = 4'd2,  OP_CLR = 4'd3,
    OP_ADD  = 4'd4,  OP_SUB = 4'd5,  OP_AND = 4'd6,  OP_OR  = 4'd7,
    OP_SWAP = 4'd8,  OP_SHL = 4'd9,  OP_SHR = 4'd10, OP_NOP = 4'd11
  } op_t;

  // True when exactly one key is pulled low.
  function automatic logic one_low(input logic [3:0] k);
    logic r;
    case (k)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Bank/key to op; mode 11 and unknown patterns decode to nop.
  function automatic op_t decode(input logic [1:0] m, input logic [3:0] k);
    op_t o;
    o = OP_NOP;
    case ({m, k})
      6'b00_1110: o = OP_PUSH;
      6'b00_1101: o = OP_POP;
      6'b00_1011: o = OP_DUP;
      6'b00_0111: o = OP_CLR;
      6'b01_1110: o = OP_ADD;
      6'b01_1101: o = OP_SUB;
      6'b01_1011: o = OP_AND;
      6'b01_0111: o = OP_OR;
      6'b10_1110: o = OP_SWAP;
      6'b10_1101: o = OP_SHL;
      6'b10_1011: o = OP_SHR;
      default:    o = OP_NOP;
    endcase
    return o;
  endfunction

  localparam logic [3:0] FULL = 4'(DEPTH);

  state_t      state_r, state_s;
  op_t         op_r, op_dec_s;
  logic [3:0]  sp_r;
  logic [3:0]  spm1_s, spm2_s;
  logic        armed_r, accept_s, fault_s, err_r, busy_r;
  logic [15:0] val_r, a_r, b_r, res_r, res_s;
  logic [15:0] top_r, next_r;

  assign op_dec_s = decode(mode, key);
  assign accept_s = (state_r == S_IDLE) && armed_r && one_low(key);
  assign spm1_s   = sp_r - 4'd1;
  assign spm2_s   = sp_r - 4'd2;

  assign top     = top_r;
  assign next    = next_r;
  assign busy    = busy_r;
  assign counter = {err_r, 3'b000, sp_r};

  // Depth check for the latched op: underflow or overflow both abort it.
  always_comb begin
    fault_s = 1'b0;
    case (op_r)
      OP_PUSH:                        fault_s = (sp_r == FULL);
      OP_POP:                         fault_s = (sp_r == 4'd0);
      OP_DUP:                         fault_s = (sp_r == 4'd0) || (sp_r == FULL);
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SWAP, OP_SHL, OP_SHR:        fault_s = (sp_r < 4'd2);
      default:                        fault_s = 1'b0;
    endcase
  end

  // Binary result, next (B) op top (A), 16-bit wrap-around.
  always_comb begin
    res_s = 16'h0000;
    case (op_r)
      OP_ADD:  res_s = b_r + a_r;
      OP_SUB:  res_s = b_r - a_r;
      OP_AND:  res_s = b_r & a_r;
      OP_OR:   res_s = b_r | a_r;
      OP_SHL:  res_s = b_r << a_r[3:0];
      OP_SHR:  res_s = b_r >> a_r[3:0];
      default: res_s = 16'h0000;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; clear/nop skip the operand read.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (op_dec_s == OP_CLR || op_dec_s == OP_NOP) state_s = S_WB;
          else                                          state_s = S_READ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_READ:    state_s = S_EXEC;
      S_EXEC:    state_s = fault_s ? S_REFRESH : S_WB;
      S_WB:      state_s = (op_r == OP_SWAP) ? S_WB2 : S_REFRESH;
      S_WB2:     state_s = S_REFRESH;
      S_REFRESH: state_s = S_IDLE;
      default:   state_s = S_IDLE;
    endcase
  end

  // FSM outputs: read addresses track sp, write port is active in WB/WB2 only.
  always_comb begin
    rf_raddr0 = spm1_s[2:0];
    rf_raddr1 = spm2_s[2:0];
    rf_we     = 1'b0;
    rf_waddr  = 3'd0;
    rf_wdata  = 16'h0000;
    case (state_r)
      S_WB: begin
        case (op_r)
          OP_PUSH: begin rf_we = 1'b1; rf_waddr = sp_r[2:0];   rf_wdata = val_r; end
          OP_DUP:  begin rf_we = 1'b1; rf_waddr = sp_r[2:0];   rf_wdata = a_r;   end
          OP_SWAP: begin rf_we = 1'b1; rf_waddr = spm1_s[2:0]; rf_wdata = b_r;   end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR: begin
            rf_we = 1'b1; rf_waddr = spm2_s[2:0]; rf_wdata = res_r;
          end
          default: rf_we = 1'b0;
        endcase
      end
      S_WB2: begin
        rf_we    = 1'b1;
        rf_waddr = spm2_s[2:0];
        rf_wdata = a_r;
      end
      default: rf_we = 1'b0;
    endcase
  end

  // Press arming: re-armed only by an all-released key sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_r <= 1'b0;
    end else if (accept_s) begin
      armed_r <= 1'b0;
    end else if (key == 4'b1111) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= armed_r;
    end
  end

  // Datapath: op latch, operand fetch, result, sp/err update, top/next refresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r   <= OP_NOP;
      val_r  <= 16'h0000;
      a_r    <= 16'h0000;
      b_r    <= 16'h0000;
      res_r  <= 16'h0000;
      sp_r   <= 4'd0;
      err_r  <= 1'b0;
      top_r  <= 16'h0000;
      next_r <= 16'h0000;
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r  <= op_dec_s;
            val_r <= val;
          end
        end
        S_READ: begin
          a_r <= rf_rdata0;
          b_r <= rf_rdata1;
        end
        S_EXEC: begin
          res_r <= res_s;
          err_r <= fault_s;
        end
        S_WB: begin
          case (op_r)
            OP_PUSH, OP_DUP:                        sp_r <= sp_r + 4'd1;
            OP_POP, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHL, OP_SHR:                         sp_r <= spm1_s;
            OP_CLR: begin sp_r <= 4'd0; err_r <= 1'b0; end
            OP_NOP: err_r <= 1'b0;
            default: sp_r <= sp_r;
          endcase
        end
        S_REFRESH: begin
          top_r  <= (sp_r >= 4'd1) ? rf_rdata0 : 16'h0000;
          next_r <= (sp_r >= 4'd2) ? rf_rdata1 : 16'h0000;
        end
        default: sp_r <= sp_r;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_seq.sv
// tb_rpn_seq: directed bench for rpn_seq with a behavioural 8x16 register
// file attached to its read/write ports.
module tb_rpn_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [3:0]  key;
  logic [15:0] val;
  logic [2:0]  rf_raddr0, rf_raddr1, rf_waddr;
  logic [15:0] rf_rdata0, rf_rdata1, rf_wdata;
  logic        rf_we;
  logic [15:0] top, next;
  logic [7:0]  counter;
  logic        busy;

  logic [15:0] rf_mem [0:7];
  int          wr_cnt = 0;

  int n_cmp = 0;
  int n_err = 0;
  int nb, lat, we_seen, bsy_seen, wc;

  rpn_seq #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .key(key), .val(val),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .top(top), .next(next), .counter(counter), .busy(busy)
  );

  always #5 clk = ~clk;

  // External register file: combinational read, write on rising edge.
  assign rf_rdata0 = rf_mem[rf_raddr0];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  always @(posedge clk) begin
    if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One press: key is down for the acceptance edge only, then released.
  // nb = busy cycles, lat = edges after acceptance until top changed (-1 none).
  task automatic do_op(input logic [1:0] m, input logic [3:0] k, input logic [15:0] v);
    logic [15:0] old_top;
    @(negedge clk);
    mode = m; key = k; val = v;
    old_top = top;
    @(posedge clk); #1;
    key = 4'b1111;
    nb = 0; lat = -1; we_seen = 0;
    for (int j = 0; j < 12; j++) begin
      if (busy) nb++;
      if (rf_we) we_seen = 1;
      if (lat < 0 && top !== old_top) lat = j;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = 16'h0000;
    rst = 1'b0; mode = 2'b00; key = 4'b1111; val = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_top", top, 16'h0000);
    check("rst_next", next, 16'h0000);
    check("rst_counter", counter, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_we", rf_we, 1'b0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);

    // pushes
    do_op(2'b00, 4'b1110, 16'h0005);
    check("push1_busy", nb, 4);
    do_op(2'b00, 4'b1110, 16'h0003);
    check("push2_top", top, 16'h0003);
    check("push2_next", next, 16'h0005);
    check("push2_counter", counter, 8'h02);

    // sub with latency
    do_op(2'b01, 4'b1101, 16'h0000);
    check("sub_top", top, 16'h0002);
    check("sub_next", next, 16'h0000);
    check("sub_counter", counter, 8'h01);
    check("sub_latency", lat, 4);
    check("sub_busy", nb, 4);

    // clear
    do_op(2'b00, 4'b0111, 16'h0000);
    check("clr_counter", counter, 8'h00);
    check("clr_top", top, 16'h0000);
    check("clr_busy", nb, 2);

    // swap
    do_op(2'b00, 4'b1110, 16'h1234);
    do_op(2'b00, 4'b1110, 16'hABCD);
    do_op(2'b10, 4'b1110, 16'h0000);
    check("swap_top", top, 16'h1234);
    check("swap_next", next, 16'hABCD);
    check("swap_busy", nb, 5);
    check("swap_latency", lat, 5);
    check("swap_counter", counter, 8'h02);

    // shifts: ABCD << 4, then BCD0 >> 3
    do_op(2'b10, 4'b1101, 16'h0000);
    check("shl_top", top, 16'hBCD0);
    check("shl_counter", counter, 8'h01);
    do_op(2'b00, 4'b1110, 16'h0003);
    do_op(2'b10, 4'b1011, 16'h0000);
    check("shr_top", top, 16'h179A);

    // underflow at depth 1
    do_op(2'b01, 4'b1110, 16'h0000);
    check("uf_counter", counter, 8'h81);
    check("uf_top", top, 16'h179A);
    check("uf_we", we_seen, 0);
    check("uf_busy", nb, 3);
    do_op(2'b00, 4'b1110, 16'h0002);
    check("uf_clear_counter", counter, 8'h02);

    // add, and, or, wrap-around add, dup, pop
    do_op(2'b01, 4'b1110, 16'h0000);
    check("add_top", top, 16'h179C);
    do_op(2'b00, 4'b1110, 16'h00F0);
    do_op(2'b01, 4'b1011, 16'h0000);
    check("and_top", top, 16'h0090);
    do_op(2'b00, 4'b1110, 16'h0F01);
    do_op(2'b01, 4'b0111, 16'h0000);
    check("or_top", top, 16'h0F91);
    do_op(2'b00, 4'b1110, 16'hFFFF);
    do_op(2'b00, 4'b1110, 16'h0002);
    do_op(2'b01, 4'b1110, 16'h0000);
    check("wrap_top", top, 16'h0001);
    check("wrap_next", next, 16'h0F91);
    do_op(2'b00, 4'b1011, 16'h0000);
    check("dup_next", next, 16'h0001);
    check("dup_counter", counter, 8'h03);
    do_op(2'b00, 4'b1101, 16'h0000);
    check("pop_next", next, 16'h0F91);
    check("pop_counter", counter, 8'h02);

    // overflow
    do_op(2'b00, 4'b0111, 16'h0000);
    for (int i = 0; i < 8; i++) do_op(2'b00, 4'b1110, 16'(i + 1));
    check("full_counter", counter, 8'h08);
    check("full_top", top, 16'h0008);
    do_op(2'b00, 4'b1110, 16'h0099);
    check("ovf_counter", counter, 8'h88);
    check("ovf_top", top, 16'h0008);
    do_op(2'b11, 4'b1110, 16'h0000);
    check("nop_counter", counter, 8'h08);
    check("nop_busy", nb, 2);

    // held pop executes once
    @(negedge clk); mode = 2'b00; key = 4'b1101;
    repeat (20) @(posedge clk);
    @(negedge clk); key = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check("held_counter", counter, 8'h07);
    check("held_top", top, 16'h0007);

    // multi-key pattern ignored
    @(negedge clk); key = 4'b1100;
    bsy_seen = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (busy) bsy_seen = 1;
    end
    check("multi_busy", bsy_seen, 0);
    check("multi_counter", counter, 8'h07);
    @(negedge clk); key = 4'b1111;
    repeat (2) @(posedge clk);

    // reset during EXEC of add
    @(negedge clk); mode = 2'b01; key = 4'b1110;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wc = wr_cnt;
    rst = 1'b0;
    #1;
    check("mid_rst_top", top, 16'h0000);
    check("mid_rst_next", next, 16'h0000);
    check("mid_rst_counter", counter, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_we", rf_we, 1'b0);
    mode = 2'b00;
    @(negedge clk); rst = 1'b1;
    bsy_seen = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (busy) bsy_seen = 1;
    end
    check("post_rst_ignored", bsy_seen, 0);
    check("post_rst_counter", counter, 8'h00);
    check("post_rst_writes", wr_cnt - wc, 0);
    @(negedge clk); key = 4'b1111;
    repeat (2) @(posedge clk);
    do_op(2'b00, 4'b1110, 16'h0077);
    check("post_rst_push_top", top, 16'h0077);
    check("post_rst_push_counter", counter, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rpn_seq.md
RPN_SEQ -- requirements
Module: rpn_seq

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 8, meaning the number of stack entries held in the external register file.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port mode, input, 2 bits: operation bank select.
REQ-005 The block SHALL have port key, input, 4 bits: pushbuttons, active-low, one-hot-low when pressed.
REQ-006 The block SHALL have port val, input, 16 bits: the push operand.
REQ-007 The block SHALL have ports rf_raddr0 and rf_raddr1, outputs, 3 bits each: register file read addresses.
REQ-008 The block SHALL have ports rf_rdata0 and rf_rdata1, inputs, 16 bits each: combinational read data for raddr0 and raddr1.
REQ-009 The block SHALL have ports rf_we (output, 1 bit), rf_waddr (output, 3 bits) and rf_wdata (output, 16 bits): the register file write port.
REQ-010 The block SHALL have ports top and next, outputs, 16 bits each: registered copies of stack[sp-1] and stack[sp-2].
REQ-011 The block SHALL have port counter, output, 8 bits: {err, 3'b0, depth[3:0]}.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 Press acceptance SHALL follow these rules.
- A press is accepted at a posedge where state = IDLE, armed = 1, and key has exactly one 0 bit.
- On acceptance, armed clears and the op and val are latched.
- armed sets only at a posedge where key = 4'b1111.
- A held key therefore executes exactly once.
- Multi-key patterns are ignored.
- Presses while busy are dropped, not queued.
REQ-014 The op decode SHALL be as follows.
- mode 00: key0 = push val, key1 = pop, key2 = dup, key3 = clear.
- mode 01: key0 = add, key1 = sub (next - top), key2 = and, key3 = or.
- mode 10: key0 = swap, key1 = shl (next << top[3:0]), key2 = shr (logical), key3 = nop.
- mode 11: all keys = nop.
REQ-015 The FSM SHALL have the states IDLE, READ, EXEC, WB, WB2 and REFRESH.
- Path is IDLE->READ->EXEC->WB->REFRESH->IDLE.
- swap inserts WB2 between WB and REFRESH.
- clear and nop go IDLE->WB->REFRESH->IDLE.
REQ-016 In READ, rf_raddr0 SHALL be sp-1 and rf_raddr1 SHALL be sp-2, and rdata0/rdata1 SHALL be latched into A (top) and B (next).
REQ-017 In EXEC, the block SHALL check depth and compute the result R, with all arithmetic 16-bit wrap-around and no carry or overflow flag.
REQ-018 rf_we SHALL be high only in WB/WB2, with writes as follows.
- push: stack[sp] <= val, sp+1.
- dup: stack[sp] <= A, sp+1.
- pop: no write, sp-1.
- binary ops: stack[sp-2] <= R, sp-1.
- swap WB: stack[sp-1] <= B.
- swap WB2: stack[sp-2] <= A.
- clear: no write, sp <= 0.
REQ-019 In REFRESH, the block SHALL read the new sp-1 and sp-2 and load top and next, forcing top to 0 when depth < 1 and next to 0 when depth < 2.
REQ-020 Latency: for a press accepted at edge N, top/next SHALL be updated at edge N+4 (N+5 for swap), and busy SHALL be high during cycles N+1 to N+4 (N+5 for swap).
REQ-021 Underflow SHALL be handled as follows.
- Triggers: pop/dup at depth 0, or binary/swap at depth < 2.
- Response: err <= 1, no write, sp unchanged, FSM goes EXEC->REFRESH.
REQ-022 Overflow SHALL be handled as follows.
- Triggers: push or dup at depth = DEPTH.
- Response: err <= 1, no write, sp unchanged.
REQ-023 err SHALL be sticky until the next op that completes without error (including nop and clear), which clears it.
REQ-024 depth SHALL equal sp, range 0..DEPTH, and SHALL never wrap.

Reset
REQ-025 While rst = 0, asynchronously, the block SHALL hold:
- state = IDLE, sp = 0, top = next = 0, counter = 0, err = 0, busy = 0.
- rf_we = 0, armed = 0.
REQ-026 Reset asserted mid-operation SHALL abort the op with no further write.
REQ-027 After reset release, a key must be observed at 4'b1111 before the first press is accepted.

Verification
REQ-028 Push case: release rst with key = 1111, then push 0x0005 and push 0x0003 (mode 00, key 1110) -> top = 0003, next = 0005, counter = 0x02.
REQ-029 Sub case: from REQ-028, mode 01, key 1101 -> top = 0002, next = 0000, counter = 0x01, with top updated exactly 4 cycles after acceptance.
REQ-030 Swap case: stack 0x1234, 0xABCD; mode 10, key 1110 -> top = 1234, next = ABCD, busy high for 5 cycles.
REQ-031 Underflow case: depth 1; mode 01, key 1110 -> counter = 0x81, top unchanged, rf_we never high; a following push clears err (counter = 0x02).
REQ-032 Overflow and held-key case: DEPTH pushes -> counter = 0x08; a ninth push -> counter = 0x88; key held at 1110 for 20 cycles executes only one op.
REQ-033 Reset case: rst low during EXEC of add -> all outputs 0 immediately, no write; a key held low through release is ignored until key = 1111 is seen.
